// File: rtl/hh_spike_detector.sv
// rtl/hh_spike_detector.sv - action potential detector for the Hodgkin-Huxley core voltage
//
// Purpose: watches the signed Q9.5 membrane voltage and reports spikes. It
// detects a threshold crossing, re-arms with hysteresis, and then applies an
// absolute refractory window. For each spike it reports a count, the peak
// voltage and the inter-spike interval.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   v_in         membrane voltage, signed Q9.5
//   v_valid      v_in qualifier; unqualified samples are ignored
//   enable       detection enable (gates only the BELOW->ABOVE crossing)
//   clear        synchronous clear of counters/status, highest priority
//   spike        one-cycle pulse per detected crossing
//   spike_count  saturating spike counter
//   overflow     sticky: spike seen while spike_count was saturated
//   isi          last inter-spike interval in cycles
//   isi_valid    one-cycle pulse when isi updates
//   peak_v       peak v_in of the last completed spike
//   state        FSM state: 0 BELOW, 1 ABOVE, 2 REFRACT

module hh_spike_detector #(
  parameter int W           = 14,
  parameter int THRESH      = 0,
  parameter int HYST        = 320,
  parameter int REFRACT_CYC = 16,
  parameter int CNT_W       = 8,
  parameter int ISI_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     v_in,
  input  logic             v_valid,
  input  logic             enable,
  input  logic             clear,
  output logic             spike,
  output logic [CNT_W-1:0] spike_count,
  output logic             overflow,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic [W-1:0]     peak_v,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_BELOW   = 2'd0,
    ST_ABOVE   = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  localparam int RC_W = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC + 1) : 1;

  // Threshold and re-arm level carried at W+1 bits so THRESH-HYST cannot wrap.
  localparam logic signed [W:0]     THR_X   = (W+1)'(THRESH);
  localparam logic signed [W:0]     REARM_X = (W+1)'(THRESH - HYST);
  localparam logic [RC_W-1:0]       RC_LOAD = RC_W'(REFRACT_CYC);
  localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ISI_W-1:0]      ISI_MAX = {ISI_W{1'b1}};

  state_t                 state_q, state_d;
  logic                   spike_q, spike_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [ISI_W-1:0]       isi_q, isi_d;
  logic                   isi_valid_q, isi_valid_d;
  logic [W-1:0]           peak_v_q, peak_v_d;
  logic signed [W-1:0]    peak_trk_q, peak_trk_d;
  logic [ISI_W-1:0]       isi_tmr_q, isi_tmr_d;
  logic                   have_prev_q, have_prev_d;
  logic [RC_W-1:0]        rc_q, rc_d;

  logic signed [W:0]      v_x;
  logic                   above_thr;
  logic                   below_rearm;
  logic                   crossing;
  logic [ISI_W-1:0]       tmr_inc;

  assign v_x         = $signed({v_in[W-1], v_in});
  assign above_thr   = (v_x >= THR_X);
  assign below_rearm = (v_x < REARM_X);
  assign crossing    = (state_q == ST_BELOW) && v_valid && enable && above_thr;
  assign tmr_inc     = (isi_tmr_q == ISI_MAX) ? isi_tmr_q : (isi_tmr_q + ISI_W'(1));

  always_comb begin
    state_d     = state_q;
    spike_d     = 1'b0;
    count_d     = count_q;
    overflow_d  = overflow_q;
    isi_d       = isi_q;
    isi_valid_d = 1'b0;
    peak_v_d    = peak_v_q;
    peak_trk_d  = peak_trk_q;
    isi_tmr_d   = tmr_inc;
    have_prev_d = have_prev_q;
    rc_d        = rc_q;

    case (state_q)
      ST_BELOW: begin
        if (crossing) begin
          state_d     = ST_ABOVE;
          peak_trk_d  = $signed(v_in);
          spike_d     = 1'b1;
          if (count_q == CNT_MAX) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
          // The timer still holds (t1 - t0 - 1) here, so +1 gives the interval.
          if (have_prev_q) begin
            isi_d       = tmr_inc;
            isi_valid_d = 1'b1;
          end
          have_prev_d = 1'b1;
          isi_tmr_d   = '0;
        end
      end

      ST_ABOVE: begin
        if (v_valid) begin
          if (below_rearm) begin
            peak_v_d = peak_trk_q;
            if (REFRACT_CYC == 0) begin
              state_d = ST_BELOW;
            end else begin
              state_d = ST_REFRACT;
              rc_d    = RC_LOAD;
            end
          end else if ($signed(v_in) > peak_trk_q) begin
            peak_trk_d = $signed(v_in);
          end
        end
      end

      ST_REFRACT: begin
        // Counts real time, not samples; <=1 also covers a counter left at 0.
        rc_d = rc_q - RC_W'(1);
        if (rc_q <= RC_W'(1)) begin
          state_d = ST_BELOW;
          rc_d    = '0;
        end
      end

      default: begin
        state_d = ST_BELOW;
        rc_d    = '0;
      end
    endcase

    if (clear) begin
      state_d     = ST_BELOW;
      spike_d     = 1'b0;
      count_d     = '0;
      overflow_d  = 1'b0;
      isi_d       = '0;
      isi_valid_d = 1'b0;
      peak_v_d    = '0;
      isi_tmr_d   = '0;
      have_prev_d = 1'b0;
      rc_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BELOW;
      spike_q     <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      isi_q       <= '0;
      isi_valid_q <= 1'b0;
      peak_v_q    <= '0;
      peak_trk_q  <= '0;
      isi_tmr_q   <= '0;
      have_prev_q <= 1'b0;
      rc_q        <= '0;
    end else begin
      state_q     <= state_d;
      spike_q     <= spike_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      isi_q       <= isi_d;
      isi_valid_q <= isi_valid_d;
      peak_v_q    <= peak_v_d;
      peak_trk_q  <= peak_trk_d;
      isi_tmr_q   <= isi_tmr_d;
      have_prev_q <= have_prev_d;
      rc_q        <= rc_d;
    end
  end

  assign spike       = spike_q;
  assign spike_count = count_q;
  assign overflow    = overflow_q;
  assign isi         = isi_q;
  assign isi_valid   = isi_valid_q;
  assign peak_v      = peak_v_q;
  assign state       = state_q;

endmodule

// File: tb/tb_hh_spike_detector.sv
// tb/tb_hh_spike_detector.sv - directed self-checking bench for hh_spike_detector

module tb_hh_spike_detector;

  logic        clk;
  logic        rst_n;
  logic [13:0] v_in;
  logic        v_valid;
  logic        enable;
  logic        clear;
  logic        spike;
  logic [7:0]  spike_count;
  logic        overflow;
  logic [15:0] isi;
  logic        isi_valid;
  logic [13:0] peak_v;
  logic [1:0]  state;

  int checks;
  int failures;
  int cyc;
  int c0;
  int nsp;

  hh_spike_detector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .v_in        (v_in),
    .v_valid     (v_valid),
    .enable      (enable),
    .clear       (clear),
    .spike       (spike),
    .spike_count (spike_count),
    .overflow    (overflow),
    .isi         (isi),
    .isi_valid   (isi_valid),
    .peak_v      (peak_v),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] mv(input int m);
    return 14'(m * 32);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [13:0] v, input logic vld);
    v_in    = v;
    v_valid = vld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    v_in     = mv(-65);
    v_valid  = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_spike", 32'(spike), 0);
    check_eq("rst_count", 32'(spike_count), 0);
    check_eq("rst_ovf", 32'(overflow), 0);
    check_eq("rst_isi", 32'(isi), 0);
    check_eq("rst_isi_valid", 32'(isi_valid), 0);
    check_eq("rst_peak", 32'(peak_v), 0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a spike
    step(mv(30), 1'b1);
    check_eq("pre_rst_spike", 32'(spike), 1);
    step(mv(30), 1'b1);
    check_eq("pre_rst_state", 32'(state), 1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", 32'(state), 0);
    check_eq("async_rst_count", 32'(spike_count), 0);
    check_eq("async_rst_spike", 32'(spike), 0);
    v_in = mv(-65);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    nsp = 0;
    for (int i = 0; i < 5; i++) begin
      step(mv(-65), 1'b1);
      nsp += 32'(spike);
    end
    check_eq("post_rst_no_spike", 32'(nsp), 0);
    check_eq("post_rst_count", 32'(spike_count), 0);

    // Ramp -65 mV to +40 mV in 1 mV steps
    c0 = 0;
    for (int m = -65; m <= 40; m++) begin
      step(mv(m), 1'b1);
      if (m == -1) check_eq("ramp_m1_spike", 32'(spike), 0);
      if (m == 0) begin
        c0 = cyc;
        check_eq("ramp_cross_spike", 32'(spike), 1);
        check_eq("ramp_cross_count", 32'(spike_count), 1);
        check_eq("ramp_cross_isi_valid", 32'(isi_valid), 0);
      end
      if (m == 1) begin
        check_eq("ramp_p1_spike", 32'(spike), 0);
        check_eq("ramp_p1_isi_valid", 32'(isi_valid), 0);
      end
    end
    step(mv(-20), 1'b1);
    check_eq("rearm_state", 32'(state), 2);
    check_eq("rearm_peak", 32'(peak_v), 32'h500);
    for (int i = 0; i < 15; i++) begin
      step(mv(-20), 1'b1);
      check_eq("refract_state", 32'(state), 2);
    end
    step(mv(-20), 1'b1);
    check_eq("refract_exit_state", 32'(state), 0);

    // Second spike crossing exactly 100 edges after the first
    while (cyc - c0 < 80) step(mv(-20), 1'b1);
    for (int m = -19; m <= 0; m++) begin
      step(mv(m), 1'b1);
    end
    check_eq("isi_spike", 32'(spike), 1);
    check_eq("isi_valid", 32'(isi_valid), 1);
    check_eq("isi_value", 32'(isi), 100);
    check_eq("isi_count", 32'(spike_count), 2);
    step(mv(1), 1'b1);
    check_eq("isi_valid_pulse", 32'(isi_valid), 0);
    check_eq("spike_pulse", 32'(spike), 0);

    // Hysteresis: toggling between +1 and -5 mV never re-arms
    nsp = 0;
    for (int i = 0; i < 50; i++) begin
      step((i % 2) != 0 ? mv(-5) : mv(1), 1'b1);
      nsp += 32'(spike);
    end
    check_eq("hyst_no_spike", 32'(nsp), 0);
    check_eq("hyst_state", 32'(state), 1);
    check_eq("hyst_count", 32'(spike_count), 2);
    step(mv(-20), 1'b1);
    check_eq("hyst_peak", 32'(peak_v), 32'h20);
    check_eq("hyst_rearm_state", 32'(state), 2);

    // Refractory: +20 mV during REFRACT is ignored, detected on first BELOW sample
    nsp = 0;
    for (int i = 1; i <= 16; i++) begin
      step(mv(20), 1'b1);
      nsp += 32'(spike);
      if (i == 15) check_eq("refr_c15_state", 32'(state), 2);
    end
    check_eq("refr_no_spike", 32'(nsp), 0);
    check_eq("refr_exit_state", 32'(state), 0);
    step(mv(20), 1'b1);
    check_eq("refr_first_below_spike", 32'(spike), 1);
    check_eq("refr_count", 32'(spike_count), 3);

    // Refractory timing independent of v_valid
    step(mv(-20), 1'b1);
    check_eq("refr2_state", 32'(state), 2);
    for (int i = 1; i <= 15; i++) step(mv(20), 1'b0);
    check_eq("refr2_c15_state", 32'(state), 2);
    step(mv(20), 1'b0);
    check_eq("refr2_exit_state", 32'(state), 0);
    check_eq("refr2_no_spike", 32'(spike), 0);
    step(mv(20), 1'b1);
    check_eq("refr2_spike", 32'(spike), 1);
    check_eq("refr2_count", 32'(spike_count), 4);

    // Saturation and overflow
    for (int k = 5; k <= 255; k++) begin
      step(mv(-20), 1'b1);
      repeat (16) step(mv(-20), 1'b1);
      step(mv(20), 1'b1);
    end
    check_eq("sat_count", 32'(spike_count), 255);
    check_eq("sat_ovf_clear", 32'(overflow), 0);
    step(mv(-20), 1'b1);
    repeat (16) step(mv(-20), 1'b1);
    step(mv(20), 1'b1);
    check_eq("ovf_spike", 32'(spike), 1);
    check_eq("ovf_count", 32'(spike_count), 255);
    check_eq("ovf_flag", 32'(overflow), 1);

    // Clear on the same edge as a crossing
    step(mv(-20), 1'b1);
    repeat (16) step(mv(-20), 1'b1);
    clear = 1'b1;
    step(mv(20), 1'b1);
    clear = 1'b0;
    check_eq("clr_spike", 32'(spike), 0);
    check_eq("clr_count", 32'(spike_count), 0);
    check_eq("clr_ovf", 32'(overflow), 0);
    check_eq("clr_state", 32'(state), 0);
    check_eq("clr_isi", 32'(isi), 0);
    check_eq("clr_peak", 32'(peak_v), 0);

    // Enable gating in BELOW, then first spike after clear has no ISI
    enable = 1'b0;
    step(mv(20), 1'b1);
    check_eq("dis_spike", 32'(spike), 0);
    check_eq("dis_state", 32'(state), 0);
    enable = 1'b1;
    step(mv(20), 1'b1);
    check_eq("en_spike", 32'(spike), 1);
    check_eq("en_count", 32'(spike_count), 1);
    check_eq("en_isi_valid", 32'(isi_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hh_spike_detector.md
Name: hh_spike_detector

Overview:
Downstream consumer of the Hodgkin-Huxley neuron core's membrane voltage output (signed Q9.5, 14 bit). Detects action potentials by threshold crossing with hysteresis and an absolute refractory window. Emits a one-cycle spike pulse, a saturating spike count, the peak voltage of each spike and the inter-spike interval (ISI) in clock cycles. Feeds the chip's output pins and debug mux.

Parameters:
W, 14, voltage word width, signed two's complement Q9.5 (5 fractional bits)
THRESH, 0, spike threshold in Q9.5 (0 mV = 14'h0000)
HYST, 320, re-arm hysteresis in Q9.5 (320 = 10.0 mV); re-arm level is THRESH-HYST
REFRACT_CYC, 16, refractory length in clock cycles after re-arm (0 = none)
CNT_W, 8, spike counter width
ISI_W, 16, ISI timer width

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
v_in  in  W  membrane voltage from neuron core, signed Q9.5
v_valid  in  1  v_in sample qualifier; samples with v_valid=0 are ignored
enable  in  1  detection enable
clear  in  1  synchronous clear of counters/status
spike  out  1  one-cycle pulse per detected spike
spike_count  out  CNT_W  saturating spike count
overflow  out  1  sticky: a spike occurred while spike_count was at max
isi  out  ISI_W  last measured inter-spike interval, cycles
isi_valid  out  1  one-cycle pulse when isi updates
peak_v  out  W  maximum v_in seen during the last completed spike
state  out  2  FSM state (debug): 0 BELOW, 1 ABOVE, 2 REFRACT

Behaviour:
- Reset (async, rst_n=0): state=BELOW, spike=0, spike_count=0, overflow=0, isi=0, isi_valid=0, peak_v=0, ISI timer=0, have_prev=0, refractory counter=0. All outputs registered.
- All voltage comparisons signed. Re-arm level THRESH-HYST computed at W+1 bits; no wrap.
- BELOW: on edge with v_valid & enable & v_in>=THRESH: go ABOVE, peak tracker<=v_in. Registered crossing event (E) on that edge: spike=1 next cycle (latency 1 from sample edge).
- ABOVE: each valid sample, peak tracker<=max(peak tracker, v_in). On valid v_in < THRESH-HYST: peak_v<=peak tracker; if REFRACT_CYC=0 go BELOW, else go REFRACT and load counter with REFRACT_CYC. Samples between re-arm and threshold: stay ABOVE.
- REFRACT: counter decrements every clk edge regardless of v_valid; leaves to BELOW on the edge where counter==1. No crossing detected in REFRACT even if v_in>=THRESH; a sample above THRESH on the first BELOW cycle is detected normally.
- enable=0: BELOW holds (no detection); ABOVE/REFRACT progress normally; ISI timer keeps counting; counts retained.
- On E: spike_count+1 saturating at 2^CNT_W-1; if already max, overflow<=1 (sticky until clear/reset).
- ISI: timer cleared to 0 on E edge, increments each later edge, saturates at 2^ISI_W-1. On E with have_prev=1: isi<=sat(timer+1), isi_valid=1 for one cycle. First E sets have_prev=1, no isi_valid. Crossings at edges t0, t1 give isi=t1-t0.
- clear=1 (sync, highest priority, also over same-edge E): spike_count, overflow, isi, peak_v, timer, have_prev <=0; state<=BELOW; refractory counter<=0; spike/isi_valid=0 next cycle.
- Reset mid-spike: immediate return to reset values; no spike pulse afterwards.

Test Plan:
- Assert rst_n=0 asynchronously mid-ABOVE (v_in=+30 mV) -> all outputs 0 and state=0 before next clk edge; after release with v_in=-65 mV (14'h37E0) no spike.
- Ramp v_in from -65 mV to +40 mV in 1 mV steps, v_valid=1 -> spike high exactly one cycle after the edge sampling 0 mV, spike_count=1, isi_valid stays 0; descend to -20 mV -> peak_v=14'h0500 (+40), state=2 for 16 cycles then 0.
- Second identical spike whose crossing edge is 100 cycles after the first -> isi=100, isi_valid one-cycle pulse, spike_count=2.
- Hysteresis: after crossing, toggle v_in between +1 mV and -5 mV for 50 samples -> exactly one spike, state stays 1.
- Refractory: after re-arm, drive v_in=+20 mV on cycles 1-15 of REFRACT -> no spike; v_in held at +20 mV -> spike on first BELOW sample; repeat with v_valid=0 during REFRACT -> exit still after 16 cycles.
- Drive 256 spikes -> spike_count=255, overflow=1; assert clear on the same edge as a crossing -> spike_count=0, overflow=0, no spike pulse, state=0.
